// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle ARM main FSM and its datapath:
// instruction fields and multiplier status in, enables and mux selects out.
interface multicycle_ctrl_if;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       MulOp;
    logic       Busy;
    logic       IRWrite;
    logic       NextPC;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic [1:0] FlagW;
    logic       NoWrite;
    logic       AdrSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUControl;
    logic [1:0] ResultSrc;
    logic [1:0] ImmSrc;
    logic [1:0] RegSrc;
    logic       MStart;

    modport master (
        input  Op, Funct, Rd, MulOp, Busy,
        output IRWrite, NextPC, PCS, RegW, MemW, FlagW, NoWrite, AdrSrc,
               ALUSrcA, ALUSrcB, ALUControl, ResultSrc, ImmSrc, RegSrc, MStart
    );

    modport slave (
        output Op, Funct, Rd, MulOp, Busy,
        input  IRWrite, NextPC, PCS, RegW, MemW, FlagW, NoWrite, AdrSrc,
               ALUSrcA, ALUSrcB, ALUControl, ResultSrc, ImmSrc, RegSrc, MStart
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle ARM core (fetch/decode/execute/mem/wb).
// Define MULTICYCLE_MUL_EN to add the MULSTART/MULWAIT/MULWB multiplier path.
module multicycle_ctrl (
    input  logic               CLK,
    input  logic               RESET,
    multicycle_ctrl_if.master  bus
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
`ifdef MULTICYCLE_MUL_EN
        , MULSTART, MULWAIT, MULWB
`endif
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [3:0] cmd;
    logic       s_bit;
    logic       i_bit;
    logic       u_bit;
    logic       l_bit;
    logic [1:0] dp_aluctl;
    logic       dp_arith;
    logic       dp_writes;

    logic       irwrite;
    logic       nextpc;
    logic       pcs;
    logic       regw;
    logic       memw;
    logic [1:0] flagw;
    logic       adrsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluctl;
    logic [1:0] resultsrc;
    logic       mstart;

    assign cmd   = bus.Funct[4:1];
    assign s_bit = bus.Funct[0];
    assign i_bit = bus.Funct[5];
    assign u_bit = bus.Funct[3];
    assign l_bit = bus.Funct[0];

`ifndef MULTICYCLE_MUL_EN
    logic unused_mul;
    assign unused_mul = bus.MulOp ^ bus.Busy;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) state <= FETCH;
        else       state <= state_next;
    end

    // Data-processing cmd decode; unlisted cmds run as ADD without a writeback
    always_comb begin
        dp_aluctl = 2'b00;
        dp_arith  = 1'b0;
        dp_writes = 1'b0;
        case (cmd)
            4'b0100: begin dp_aluctl = 2'b00; dp_arith = 1'b1; dp_writes = 1'b1; end
            4'b0010: begin dp_aluctl = 2'b01; dp_arith = 1'b1; dp_writes = 1'b1; end
            4'b1010: begin dp_aluctl = 2'b01; dp_arith = 1'b1; end
            4'b1011: begin dp_aluctl = 2'b00; dp_arith = 1'b1; end
            4'b0000: begin dp_aluctl = 2'b10; dp_writes = 1'b1; end
            4'b1100: begin dp_aluctl = 2'b11; dp_writes = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        state_next = FETCH;
        irwrite    = 1'b0;
        nextpc     = 1'b0;
        pcs        = 1'b0;
        regw       = 1'b0;
        memw       = 1'b0;
        flagw      = 2'b00;
        adrsrc     = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        aluctl     = 2'b00;
        resultsrc  = 2'b00;
        mstart     = 1'b0;
        case (state)
            FETCH: begin
                irwrite    = 1'b1;
                nextpc     = 1'b1;
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                resultsrc  = 2'b10;
                state_next = DECODE;
            end
            DECODE: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                case (bus.Op)
                    2'b01: state_next = MEMADR;
                    2'b10: state_next = BRANCH;
                    2'b00: begin
                        if (i_bit) state_next = EXECI;
`ifdef MULTICYCLE_MUL_EN
                        else if (bus.MulOp) state_next = MULSTART;
`endif
                        else state_next = EXECR;
                    end
                    default: state_next = FETCH;
                endcase
            end
            MEMADR: begin
                alusrcb    = 2'b01;
                aluctl     = u_bit ? 2'b00 : 2'b01;
                state_next = l_bit ? MEMRD : MEMWR;
            end
            MEMRD: begin
                adrsrc     = 1'b1;
                state_next = MEMWB;
            end
            MEMWB: begin
                regw      = 1'b1;
                resultsrc = 2'b01;
                pcs       = (bus.Rd == 4'd15);
            end
            MEMWR: begin
                adrsrc = 1'b1;
                memw   = 1'b1;
            end
            EXECR, EXECI: begin
                alusrcb    = (state == EXECI) ? 2'b01 : 2'b00;
                aluctl     = dp_aluctl;
                flagw      = {s_bit, s_bit & dp_arith};
                state_next = ALUWB;
            end
            ALUWB: begin
                regw = 1'b1;
                pcs  = (bus.Rd == 4'd15);
            end
            BRANCH: begin
                alusrcb   = 2'b01;
                resultsrc = 2'b10;
                pcs       = 1'b1;
            end
`ifdef MULTICYCLE_MUL_EN
            MULSTART: begin
                mstart     = 1'b1;
                state_next = MULWAIT;
            end
            MULWAIT: begin
                state_next = bus.Busy ? MULWAIT : MULWB;
            end
            MULWB: begin
                regw      = 1'b1;
                resultsrc = 2'b11;
            end
`endif
            default: state_next = FETCH;
        endcase
    end

    // Reset squashes every write enable and parks the selects at their FETCH values
    assign bus.IRWrite    = irwrite & ~RESET;
    assign bus.NextPC     = nextpc & ~RESET;
    assign bus.PCS        = pcs & ~RESET;
    assign bus.RegW       = regw & ~RESET;
    assign bus.MemW       = memw & ~RESET;
    assign bus.FlagW      = RESET ? 2'b00 : flagw;
    assign bus.MStart     = mstart & ~RESET;
    assign bus.AdrSrc     = RESET ? 1'b0  : adrsrc;
    assign bus.ALUSrcA    = RESET ? 1'b1  : alusrca;
    assign bus.ALUSrcB    = RESET ? 2'b10 : alusrcb;
    assign bus.ALUControl = RESET ? 2'b00 : aluctl;
    assign bus.ResultSrc  = RESET ? 2'b10 : resultsrc;

    assign bus.NoWrite = (bus.Op == 2'b00) & ~dp_writes;
    assign bus.ImmSrc  = bus.Op;
    assign bus.RegSrc  = {bus.Op == 2'b01, bus.Op == 2'b10};

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed instructions then random ones, each
// cycle's outputs compared against a per-instruction expected-cycle list.
module tb_multicycle_ctrl;

    logic CLK = 1'b0;
    logic RESET;

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

`ifdef MULTICYCLE_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    typedef struct packed {
        logic       irwrite;
        logic       nextpc;
        logic       pcs;
        logic       regw;
        logic       memw;
        logic [1:0] flagw;
        logic       nowrite;
        logic       adrsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluctl;
        logic [1:0] resultsrc;
        logic [1:0] immsrc;
        logic [1:0] regsrc;
        logic       mstart;
    } out_t;

    int   n_pass  = 0;
    int   n_total = 0;
    out_t exp_q[$];
    int   busy_q[$];   // 0/1 = drive that value, 2 = don't care (random)

    function automatic out_t observe();
        out_t o;
        o.irwrite   = bus.IRWrite;
        o.nextpc    = bus.NextPC;
        o.pcs       = bus.PCS;
        o.regw      = bus.RegW;
        o.memw      = bus.MemW;
        o.flagw     = bus.FlagW;
        o.nowrite   = bus.NoWrite;
        o.adrsrc    = bus.AdrSrc;
        o.alusrca   = bus.ALUSrcA;
        o.alusrcb   = bus.ALUSrcB;
        o.aluctl    = bus.ALUControl;
        o.resultsrc = bus.ResultSrc;
        o.immsrc    = bus.ImmSrc;
        o.regsrc    = bus.RegSrc;
        o.mstart    = bus.MStart;
        return o;
    endfunction

    task automatic check(input string tag, input out_t obs, input out_t exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Fields that follow the instruction bits regardless of state
    function automatic out_t base_of(input logic [1:0] op, input logic [5:0] f);
        out_t b;
        logic [3:0] c;
        c = f[4:1];
        b = '0;
        b.immsrc  = op;
        b.regsrc  = {op == 2'b01, op == 2'b10};
        b.nowrite = (op == 2'b00) && !(c inside {4'b0100, 4'b0010, 4'b0000, 4'b1100});
        return b;
    endfunction

    function automatic out_t reset_vec(input logic [1:0] op, input logic [5:0] f);
        out_t r;
        r = base_of(op, f);
        r.alusrca   = 1'b1;
        r.alusrcb   = 2'b10;
        r.resultsrc = 2'b10;
        return r;
    endfunction

    function automatic logic [1:0] alu_of(input logic [3:0] c);
        case (c)
            4'b0010, 4'b1010: return 2'b01;
            4'b0000:          return 2'b10;
            4'b1100:          return 2'b11;
            default:          return 2'b00;
        endcase
    endfunction

    task automatic push(input out_t v, input int b);
        exp_q.push_back(v);
        busy_q.push_back(b);
    endtask

    // Expected output of every cycle an instruction occupies, FETCH first
    task automatic build(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd,
                         input logic mulop, input int n_busy);
        out_t b, v;
        logic [3:0] c;
        c = f[4:1];
        exp_q.delete();
        busy_q.delete();
        b = base_of(op, f);
        v = b; v.irwrite = 1; v.nextpc = 1; v.alusrca = 1; v.alusrcb = 2'b10; v.resultsrc = 2'b10;
        push(v, 2);
        v = b; v.alusrca = 1; v.alusrcb = 2'b10;
        push(v, 2);
        if (op == 2'b01) begin
            v = b; v.alusrcb = 2'b01; v.aluctl = f[3] ? 2'b00 : 2'b01;
            push(v, 2);
            if (f[0]) begin
                v = b; v.adrsrc = 1;
                push(v, 2);
                v = b; v.regw = 1; v.resultsrc = 2'b01; v.pcs = (rd == 4'd15);
                push(v, 2);
            end else begin
                v = b; v.adrsrc = 1; v.memw = 1;
                push(v, 2);
            end
        end else if (op == 2'b10) begin
            v = b; v.alusrcb = 2'b01; v.resultsrc = 2'b10; v.pcs = 1;
            push(v, 2);
        end else if (op == 2'b00) begin
            if (MUL_EN && !f[5] && mulop) begin
                v = b; v.mstart = 1;
                push(v, 2);
                for (int k = 0; k <= n_busy; k++) push(b, (k < n_busy) ? 1 : 0);
                v = b; v.regw = 1; v.resultsrc = 2'b11;
                push(v, 2);
            end else begin
                v = b; v.alusrcb = f[5] ? 2'b01 : 2'b00; v.aluctl = alu_of(c);
                v.flagw = {f[0], f[0] && (c inside {4'b0100, 4'b0010, 4'b1010, 4'b1011})};
                push(v, 2);
                v = b; v.regw = 1; v.pcs = (rd == 4'd15);
                push(v, 2);
            end
        end
    endtask

    // Runs one instruction from its FETCH cycle; abort_at >= 0 pulses RESET at that cycle
    task automatic run_instr(input string tag, input logic [1:0] op, input logic [5:0] f,
                             input logic [3:0] rd, input logic mulop, input int n_busy,
                             input int abort_at);
        build(op, f, rd, mulop, n_busy);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge CLK);
            if (i == 0) begin
                bus.Op = op; bus.Funct = f; bus.Rd = rd; bus.MulOp = mulop;
            end
            bus.Busy = (busy_q[i] == 2) ? 1'($urandom_range(1)) : 1'(busy_q[i]);
            if (i == abort_at) begin
                bus.Busy = 1'b1;
                RESET = 1'b1;
                #1;
                check($sformatf("%s abort c%0d", tag, i), observe(), reset_vec(op, f));
                @(posedge CLK);
                #1;
                RESET = 1'b0;
                return;
            end
            #1;
            check($sformatf("%s c%0d", tag, i), observe(), exp_q[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] op;
        logic [5:0] f;
        logic [3:0] rd;
        logic       mulop;
        int         nb;
        int         ab;

        RESET     = 1'b1;
        bus.Op    = 2'b00;
        bus.Funct = 6'b001001;
        bus.Rd    = 4'd1;
        bus.MulOp = 1'b0;
        bus.Busy  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            #1;
            check($sformatf("reset c%0d", i), observe(), reset_vec(2'b00, 6'b001001));
        end
        @(posedge CLK);
        #1;
        RESET = 1'b0;

        run_instr("adds",  2'b00, 6'b001001, 4'd1,  1'b0, 0, -1);
        run_instr("ldr15", 2'b01, 6'b010001, 4'd15, 1'b0, 0, -1);
        run_instr("str",   2'b01, 6'b011000, 4'd2,  1'b0, 0, -1);
        run_instr("cmp",   2'b00, 6'b010101, 4'd0,  1'b0, 0, -1);
        run_instr("orri",  2'b00, 6'b111000, 4'd15, 1'b0, 0, -1);
        run_instr("b",     2'b10, 6'b000000, 4'd0,  1'b0, 0, -1);
        run_instr("undef", 2'b11, 6'b000000, 4'd0,  1'b0, 0, -1);
        run_instr("mul3",  2'b00, 6'b000000, 4'd4,  1'b1, 3, -1);
        run_instr("mul0",  2'b00, 6'b000001, 4'd5,  1'b1, 0, -1);
        run_instr("mulrst", 2'b00, 6'b000000, 4'd4, 1'b1, 3, 4);
        run_instr("post",  2'b00, 6'b001000, 4'd3,  1'b0, 0, -1);
        run_instr("ldrrst", 2'b01, 6'b011001, 4'd7, 1'b0, 0, 3);
        run_instr("sub",   2'b00, 6'b000100, 4'd6,  1'b0, 0, -1);

        for (int n = 0; n < 40; n++) begin
            op    = 2'($urandom_range(3));
            f     = 6'($urandom_range(63));
            rd    = 4'($urandom_range(15));
            mulop = (op == 2'b00 && !f[5]) ? 1'($urandom_range(1)) : 1'b0;
            nb    = $urandom_range(4);
            build(op, f, rd, mulop, nb);
            ab    = ($urandom_range(7) == 0) ? $urandom_range(exp_q.size() - 1) : -1;
            run_instr($sformatf("rnd%0d", n), op, f, rd, mulop, nb, ab);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
